// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwr_pkg.sv
// Shared types and default constants for the idle/wake power front-end.
package gf180mcu_fd_sc_mcu7t5v0__pwr_pkg;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_IDLE_CYCLES = 16;
  localparam int unsigned STATE_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    ACTIVE = 2'd0,
    COUNT  = 2'd1,
    REQ    = 2'd2,
    SLEEP  = 2'd3
  } pwr_state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sat_cnt.sv
// Saturating up-counter with synchronous clear (clear has priority) and increment enable.
module gf180mcu_fd_sc_mcu7t5v0__sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count up on enable, hold at all-ones, return to zero on clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor3_idle_filter.sv
// Idle qualifier for power-gating islands: NOR3 of activity lines, qualified idle
// count, then a sleep request/acknowledge handshake with a wake pulse on exit.
module gf180mcu_fd_sc_mcu7t5v0__nor3_idle_filter
  import gf180mcu_fd_sc_mcu7t5v0__pwr_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               A1,
  input  logic               A2,
  input  logic               A3,
  input  logic               SLEEP_ACK,
  output logic               ZN,
  output logic               SLEEP_REQ,
  output logic               WAKE,
  output logic [STATE_W-1:0] STATE,
  inout  wire                VDD,
  inout  wire                VSS
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

  // Supply pins carry no logic; fold them into a deliberately unused net.
  wire unused_supply = &{1'b0, VDD, VSS};

  pwr_state_t       state;
  logic             nor_i;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt;

  assign nor_i = ~(A1 | A2 | A3);
  assign STATE = state;

  // Counter control: clear whenever idle breaks or the FSM resets, count while qualifying.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (RST || !nor_i) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state)
        ACTIVE:  cnt_inc = 1'b1;
        COUNT:   cnt_inc = (cnt != CNT_LAST);
        default: cnt_inc = 1'b0;
      endcase
    end
  end

  gf180mcu_fd_sc_mcu7t5v0__sat_cnt #(
    .W (CNT_W)
  ) u_sat_cnt (
    .clk (CLK),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt)
  );

  // State register plus registered outputs; reset dominates, activity beats acknowledge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ACTIVE;
      ZN        <= 1'b0;
      SLEEP_REQ <= 1'b0;
      WAKE      <= 1'b0;
    end else begin
      ZN   <= nor_i;
      WAKE <= 1'b0;
      unique case (state)
        ACTIVE: begin
          SLEEP_REQ <= 1'b0;
          if (nor_i) begin
            state <= COUNT;
          end
        end
        COUNT: begin
          if (!nor_i) begin
            state     <= ACTIVE;
            SLEEP_REQ <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state     <= REQ;
            SLEEP_REQ <= 1'b1;
          end
        end
        REQ: begin
          if (!nor_i) begin
            state     <= ACTIVE;
            SLEEP_REQ <= 1'b0;
          end else if (SLEEP_ACK) begin
            state     <= SLEEP;
            SLEEP_REQ <= 1'b1;
          end
        end
        SLEEP: begin
          if (!nor_i) begin
            state     <= ACTIVE;
            SLEEP_REQ <= 1'b0;
            WAKE      <= 1'b1;
          end
        end
        default: begin
          state     <= ACTIVE;
          SLEEP_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nor3_idle_filter.sv
// Directed bench for the NOR3 idle filter with IDLE_CYCLES=16.
module tb_gf180mcu_fd_sc_mcu7t5v0__nor3_idle_filter;

  logic       clk;
  logic       rst;
  logic       a1, a2, a3;
  logic       sleep_ack;
  logic       zn;
  logic       sleep_req;
  logic       wake;
  logic [1:0] state;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int errors = 0;
  int checks = 0;

  gf180mcu_fd_sc_mcu7t5v0__nor3_idle_filter #(
    .CNT_W       (8),
    .IDLE_CYCLES (16)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .A1        (a1),
    .A2        (a2),
    .A3        (a3),
    .SLEEP_ACK (sleep_ack),
    .ZN        (zn),
    .SLEEP_REQ (sleep_req),
    .WAKE      (wake),
    .STATE     (state),
    .VDD       (vdd),
    .VSS       (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a1 = 1'b1; a2 = 1'b0; a3 = 1'b0; sleep_ack = 1'b0;
    step(2);
    checks++; if (zn !== 1'b0) begin errors++; $display("FAIL reset_zn got=%b exp=0", zn); end
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", sleep_req); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL reset_wake got=%b exp=0", wake); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    rst = 1'b0;
    step(1);
    checks++; if (zn !== 1'b0) begin errors++; $display("FAIL post_reset_zn got=%b exp=0", zn); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_state got=%0d exp=0", state); end
  endtask

  task automatic test_idle_latency();
    a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    step(1);
    checks++; if (zn !== 1'b1) begin errors++; $display("FAIL lat_zn got=%b exp=1", zn); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lat_state_count got=%0d exp=1", state); end
    step(14);
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL lat_req_early got=%b exp=0", sleep_req); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lat_state_15 got=%0d exp=1", state); end
    step(1);
    checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL lat_req_16 got=%b exp=1", sleep_req); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL lat_state_req got=%0d exp=2", state); end
    do_reset();
  endtask

  task automatic test_restart();
    a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    step(10);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_cnt_state got=%0d exp=1", state); end
    a2 = 1'b1;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL restart_state got=%0d exp=0", state); end
    checks++; if (zn !== 1'b0) begin errors++; $display("FAIL restart_zn got=%b exp=0", zn); end
    a2 = 1'b0;
    step(15);
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL restart_req_early got=%b exp=0", sleep_req); end
    step(1);
    checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL restart_req got=%b exp=1", sleep_req); end
  endtask

  // Entered with the DUT in REQ.
  task automatic test_abort_race();
    sleep_ack = 1'b1; a3 = 1'b1;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state got=%0d exp=0", state); end
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL abort_req got=%b exp=0", sleep_req); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL abort_wake got=%b exp=0", wake); end
    sleep_ack = 1'b0; a3 = 1'b0;
  endtask

  task automatic test_sleep_wake();
    a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    step(16);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL sw_req_state got=%0d exp=2", state); end
    sleep_ack = 1'b1;
    step(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL sw_sleep_state got=%0d exp=3", state); end
    checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL sw_sleep_req got=%b exp=1", sleep_req); end
    sleep_ack = 1'b0;
    step(5);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL sw_hold_state got=%0d exp=3", state); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL sw_hold_wake got=%b exp=0", wake); end
    checks++; if (sleep_req !== 1'b1) begin errors++; $display("FAIL sw_hold_req got=%b exp=1", sleep_req); end
    a1 = 1'b1;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL sw_wake_state got=%0d exp=0", state); end
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL sw_wake_req got=%b exp=0", sleep_req); end
    checks++; if (wake !== 1'b1) begin errors++; $display("FAIL sw_wake_pulse got=%b exp=1", wake); end
    step(1);
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL sw_wake_width got=%b exp=0", wake); end
  endtask

  task automatic test_reset_in_sleep();
    a1 = 1'b0; a2 = 1'b0; a3 = 1'b0;
    step(16);
    sleep_ack = 1'b1;
    step(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL rs_sleep_state got=%0d exp=3", state); end
    sleep_ack = 1'b0;
    rst = 1'b1;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rs_state got=%0d exp=0", state); end
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL rs_req got=%b exp=0", sleep_req); end
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL rs_wake got=%b exp=0", wake); end
    checks++; if (zn !== 1'b0) begin errors++; $display("FAIL rs_zn got=%b exp=0", zn); end
    rst = 1'b0;
    step(1);
    checks++; if (wake !== 1'b0) begin errors++; $display("FAIL rs_wake_after got=%b exp=0", wake); end
  endtask

  task automatic test_ack_ignored();
    do_reset();
    a1 = 1'b1; sleep_ack = 1'b1;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ack_active_state got=%0d exp=0", state); end
    sleep_ack = 1'b0;
    step(1);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ack_active_state2 got=%0d exp=0", state); end
    a1 = 1'b0; sleep_ack = 1'b1;
    step(2);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ack_count_state got=%0d exp=1", state); end
    checks++; if (sleep_req !== 1'b0) begin errors++; $display("FAIL ack_count_req got=%b exp=0", sleep_req); end
    sleep_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_latency();
    test_restart();
    test_abort_race();
    test_sleep_wake();
    test_reset_in_sleep();
    test_ack_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
